// File: rtl/id_stage_pipe.sv
// Pipelined MIPS decode stage: decodes ALU/shift/LUI/LW/SW and reads the register file.
// Forwards from EX/MEM, stalls on load-use, and registers results into ID/EX with valid/ready handshakes.
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    output logic                  rega_rd,
    output logic [REG_ADDR_W-1:0] rega_addr,
    output logic                  regb_rd,
    output logic [REG_ADDR_W-1:0] regb_addr,
    input  logic [DATA_W-1:0]     rega_data_i,
    input  logic [DATA_W-1:0]     regb_data_i,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0]     ex_data,
    input  logic                  ex_is_load,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_W-1:0]       op,
    output logic [DATA_W-1:0]     rega_data,
    output logic [DATA_W-1:0]     regb_data,
    output logic [DATA_W-1:0]     store_data,
    output logic                  regc_wr,
    output logic [REG_ADDR_W-1:0] regc_addr,
    output logic                  illegal
);
    localparam logic [OP_W-1:0] OP_NONE = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4,
        OP_XOR = 5, OP_SLL = 6, OP_SRL = 7, OP_SRA = 8, OP_ADDI = 9, OP_ANDI = 10,
        OP_ORI = 11, OP_XORI = 12, OP_LUI = 13, OP_LW = 14, OP_SW = 15;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [DATA_W-1:0]     st;
        logic                  wr;
        logic [REG_ADDR_W-1:0] c;
        logic                  ill;
    } idex_t;

    logic [5:0]            opc, funct;
    logic [4:0]            shamt;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     imm_s, imm_z, shamt_z, fa, fb;
    logic                  r_alu, shift, i_alu, stall, accept, vld_q;
    logic [OP_W-1:0]       dop;
    idex_t                 d, q;

    assign opc     = inst[31:26];
    assign funct   = inst[5:0];
    assign shamt   = inst[10:6];
    assign rs      = REG_ADDR_W'(inst[25:21]);
    assign rt      = REG_ADDR_W'(inst[20:16]);
    assign rd      = REG_ADDR_W'(inst[15:11]);
    assign imm_s   = {{(DATA_W-16){inst[15]}}, inst[15:0]};
    assign imm_z   = DATA_W'(inst[15:0]);
    assign shamt_z = DATA_W'(shamt);

    always_comb begin
        dop = OP_NONE;
        case (opc)
            6'h00: case (funct)
                6'h20: if (shamt == 5'd0) dop = OP_ADD;
                6'h22: if (shamt == 5'd0) dop = OP_SUB;
                6'h24: if (shamt == 5'd0) dop = OP_AND;
                6'h25: if (shamt == 5'd0) dop = OP_OR;
                6'h26: if (shamt == 5'd0) dop = OP_XOR;
                6'h00: if (inst[25:21] == 5'd0) dop = OP_SLL;
                6'h02: if (inst[25:21] == 5'd0) dop = OP_SRL;
                6'h03: if (inst[25:21] == 5'd0) dop = OP_SRA;
                default: dop = OP_NONE;
            endcase
            6'h08: dop = OP_ADDI;
            6'h0C: dop = OP_ANDI;
            6'h0D: dop = OP_ORI;
            6'h0E: dop = OP_XORI;
            6'h0F: if (inst[25:21] == 5'd0) dop = OP_LUI;
            6'h23: dop = OP_LW;
            6'h2B: dop = OP_SW;
            default: dop = OP_NONE;
        endcase
    end

    assign r_alu     = (dop >= OP_ADD) && (dop <= OP_XOR);
    assign shift     = (dop >= OP_SLL) && (dop <= OP_SRA);
    assign i_alu     = (dop >= OP_ADDI) && (dop <= OP_XORI);
    // Shifts take their single register operand from rt, presented on port A.
    assign rega_rd   = r_alu || shift || i_alu || dop == OP_LW || dop == OP_SW;
    assign rega_addr = rega_rd ? (shift ? rt : rs) : '0;
    assign regb_rd   = r_alu || dop == OP_SW;
    assign regb_addr = regb_rd ? rt : '0;

    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] rf,
        input logic e_wr, input logic e_ld, input logic [REG_ADDR_W-1:0] e_addr,
        input logic [DATA_W-1:0] e_data, input logic m_wr, input logic [REG_ADDR_W-1:0] m_addr,
        input logic [DATA_W-1:0] m_data);
        if (a == '0)                            return '0;
        else if (e_wr && !e_ld && e_addr == a)  return e_data;
        else if (m_wr && m_addr == a)           return m_data;
        else                                    return rf;
    endfunction

    assign fa = fwd(rega_addr, rega_data_i, ex_wr, ex_is_load, ex_addr, ex_data, mem_wr, mem_addr, mem_data);
    assign fb = fwd(regb_addr, regb_data_i, ex_wr, ex_is_load, ex_addr, ex_data, mem_wr, mem_addr, mem_data);

    assign stall = ex_wr && ex_is_load && ex_addr != '0 &&
                   ((rega_rd && rega_addr == ex_addr) || (regb_rd && regb_addr == ex_addr));
    assign in_ready = !rst && !flush && !stall && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        d     = '0;
        d.op  = dop;
        d.ill = (dop == OP_NONE);
        d.wr  = (dop != OP_NONE) && (dop != OP_SW);
        d.c   = d.wr ? ((r_alu || shift) ? rd : rt) : '0;
        d.a   = (dop == OP_LUI) ? imm_z : (rega_rd ? fa : '0);
        if (r_alu)                                   d.b = fb;
        else if (shift)                              d.b = shamt_z;
        else if (dop == OP_ADDI || dop == OP_LW || dop == OP_SW) d.b = imm_s;
        else if (i_alu)                              d.b = imm_z;
        d.st  = (dop == OP_SW) ? fb : '0;
    end

    // Flush and reset both clear the whole register; a drained slot keeps data but drops wr/illegal.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= 1'b0;
            q     <= '0;
        end else if (accept) begin
            vld_q <= 1'b1;
            q     <= d;
        end else if (!vld_q || out_ready) begin
            vld_q <= 1'b0;
            q.wr  <= 1'b0;
            q.ill <= 1'b0;
        end
    end

    assign out_valid  = vld_q;
    assign op         = q.op;
    assign rega_data  = q.a;
    assign regb_data  = q.b;
    assign store_data = q.st;
    assign regc_wr    = q.wr;
    assign regc_addr  = q.c;
    assign illegal    = q.ill;
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Pipelined MIPS instruction-decode stage and the successor to the combinational decoder. It decodes R/I-type ALU, shift, LUI, LW and SW instructions, and reads the register file. It resolves RAW hazards by forwarding from EX/MEM and stalling on load-use. Results are registered into an ID/EX output register with valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, register/operand data width (immediates extended to DATA_W)
REG_ADDR_W, 5, register address width
OP_W, 6, internal op code width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  IF presents instruction
in_ready  out  1  ID accepts instruction this cycle
inst  in  32  instruction word
rega_rd  out  1  regfile port A read enable (combinational from inst)
rega_addr  out  REG_ADDR_W  port A address (combinational)
regb_rd  out  1  regfile port B read enable (combinational)
regb_addr  out  REG_ADDR_W  port B address (combinational)
rega_data_i  in  DATA_W  regfile port A data
regb_data_i  in  DATA_W  regfile port B data
ex_wr / ex_addr / ex_data  in  1 / REG_ADDR_W / DATA_W  EX-stage pending write
ex_is_load  in  1  EX-stage instruction is LW (data not yet available)
mem_wr / mem_addr / mem_data  in  1 / REG_ADDR_W / DATA_W  MEM-stage pending write
flush  in  1  kill instruction in ID and ID/EX register
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts
op  out  OP_W  decoded op: NONE=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SRL=7 SRA=8 ADDI=9 ANDI=10 ORI=11 XORI=12 LUI=13 LW=14 SW=15
rega_data, regb_data  out  DATA_W  operands
store_data  out  DATA_W  rt value for SW (0 otherwise)
regc_wr  out  1  destination write enable
regc_addr  out  REG_ADDR_W  destination address
illegal  out  1  registered: instruction was undecodable

Behaviour:
- Decode:
  - R-type (opcode 0, funct 20/22/24/25/26 hex, shamt 0): A=rs, B=rt, C=rd.
  - SLL/SRL/SRA (funct 00/02/03, rs=0): A reads rt; rega_data=rt value; regb_data=zero-extended shamt; C=rd.
  - ADDI: sign-extended immediate. ANDI/ORI/XORI: zero-extended immediate. All three: A=rs, C=rt.
  - LUI (rs=0): no reads; rega_data=imm zero-extended; C=rt.
  - LW (23h): A=rs, regb_data=sign-extended imm, C=rt.
  - SW (2Bh): A=rs, B=rt, regb_data=sign-extended imm, store_data=rt value, regc_wr=0.
  - Anything else: op=NONE, no reads, regc_wr=0, illegal=1 (still a valid slot).
- Operand source per read port, priority order:
  - addr 0 → 0;
  - ex_wr & !ex_is_load & ex_addr match → ex_data;
  - mem_wr & mem_addr match → mem_data;
  - else regfile data.
- Load-use stall: ex_wr & ex_is_load & nonzero ex_addr equals an enabled source address → stall=1.
- in_ready = !rst & !flush & !stall & (!out_valid | out_ready).
- ID/EX register, 1-cycle latency:
  - load when in_valid & in_ready.
  - Else if out_ready (or stall with EX free) → out_valid=0 (bubble).
  - While out_valid & !out_ready, all outputs hold stable.
- flush: next cycle out_valid=0, regc_wr=0, illegal=0; the input instruction is not consumed. Flush beats stall and load.
- Reset (any cycle, including mid-stall or mid-backpressure): next cycle all registered outputs = 0 (out_valid=0, op=NONE, data/addr 0, regc_wr=0, illegal=0); in_ready=0 while rst high.
- A bubble or NONE slot always has regc_wr=0.

Test Plan:
- Forwarding:
  - Stimulus: ADD $3,$1,$2 with ex_wr=1, ex_addr=1, ex_data=0x10, mem_wr=1, mem_addr=1, mem_data=0x20, regb_data_i=5.
  - Required: rega_data=0x10, regb_data=5, op=1, regc_addr=3, out_valid=1 one cycle later.
- Load-use:
  - Stimulus: ex_is_load=1, ex_wr=1, ex_addr=4; inst=ADDI $5,$4,-1.
  - Required: in_ready=0 and a bubble (out_valid=0). When ex_is_load drops, the instruction issues with regb_data=0xFFFFFFFF.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after SLL $2,$7,4 is accepted.
  - Required: outputs hold rega_data=$7 value, regb_data=4; in_ready=0.
  - Then out_ready=1 → next instruction loads.
- Flush:
  - Stimulus: flush while LUI $1,0x1234 is in ID/EX and XORI is at the input.
  - Required: out_valid=0 next cycle; XORI is not consumed (in_ready=0).
- Illegal and $0:
  - Stimulus: opcode 3Fh.
  - Required: op=0, illegal=1, regc_wr=0.
  - Stimulus: ADD $1,$0,$0 with ex_addr=0, ex_data=9.
  - Required: operands 0.
- Reset mid-stall:
  - Stimulus: assert rst during a load-use stall.
  - Required: next cycle all outputs 0; after release, the first valid instruction decodes normally.
